pixel_dispatcher: RTL
=====================

Name: pixel_dispatcher

Overview:
- Frame-level scheduler that walks the screen in raster order and issues one pixel coordinate per cycle to a pool of pixel engines.
- Shares the engines round-robin and throttles issue using each engine's busy flag and its result-queue full flag.
- Sits upstream of the engines. Their per-engine reorder queues and the combinator consume results in the same raster order this block issues.

Parameters:
- NUM_ENGINES, 4, number of pixel engines/queues arbitrated.
- ENG_IDX_WIDTH, 2, width of the round-robin pointer; equals clog2(NUM_ENGINES).
- PIXEL_DATA_WIDTH, 10, coordinate width.
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle request to render a frame; honoured only in IDLE.
- eng_busy  in  NUM_ENGINES  bit k high while engine k is computing.
- queue_full  in  NUM_ENGINES  bit k is the full_queue flag of engine k's reorder queue.
- eng_start  out  NUM_ENGINES  one-hot, one-cycle issue strobe to engine k.
- xpixel_o  out  PIXEL_DATA_WIDTH  x of the issued pixel; valid only while eng_start is nonzero.
- ypixel_o  out  PIXEL_DATA_WIDTH  y of the issued pixel; valid only while eng_start is nonzero.
- frame_busy  out  1  high from leaving IDLE until the cycle of frame_done.
- frame_done  out  1  one-cycle pulse when the frame is fully issued and all engines are idle.

Behaviour:
- Reset: synchronous, active-high, applied on the clk edge. Overrides everything, including mid-frame.
  - State goes to IDLE; x/y counters and the RR pointer go to 0.
  - eng_start=0, xpixel_o=0, ypixel_o=0, frame_busy=0, frame_done=0.
  - No frame_done is generated for an aborted frame.
- States: IDLE, DISPATCH, DRAIN, DONE. All outputs are registered.
  - IDLE: frame_start=1 -> DISPATCH, with x=0, y=0, frame_busy=1 on the next cycle. frame_start in any other state is ignored.
  - DISPATCH: each cycle, compute eligible[k] = !eng_busy[k] && !queue_full[k] && !last_issue[k].
    - last_issue is eng_start from the previous cycle. It masks the single cycle before engine busy rises.
    - If any engine is eligible, grant the first eligible k searching from the RR pointer upward, modulo NUM_ENGINES.
    - A grant registers eng_start=onehot(k) and xpixel_o/ypixel_o equal to the current counter values. Latency is one cycle from the eligibility sample to the strobe.
    - A grant sets the pointer to (k+1) mod NUM_ENGINES.
    - If no engine is eligible: eng_start=0, and the counters and pointer hold.
  - Counter advance: on a grant, x increments. At x==X_SIZE-1, x wraps to 0 and y increments.
    - A grant at (X_SIZE-1, Y_SIZE-1) is the final issue and transitions to DRAIN.
    - The counters never exceed their ranges.
  - DRAIN: eng_start=0. Stay until eng_busy==0 for a full sampled cycle, then go to DONE.
    - The cycle right after the final issue counts as busy, because of the last_issue mask.
  - DONE: frame_done=1 and frame_busy=0 for exactly one cycle, then IDLE.
- At most one issue per cycle. Issue order is strictly raster order, regardless of which engine is granted.
- Simultaneous events:
  - queue_full rising in the same cycle the pointer selects that engine: the grant is denied and the next eligible engine wins.
  - All engines blocked: DISPATCH stalls indefinitely, with no timeout.
  - frame_start together with reset: reset wins.
- Throughput: with all engines free, N consecutive cycles issue pixels to engines p, p+1, ... in order.

Decomposition:
- Shared package: PIXEL_DATA_WIDTH, RBG_SIZE, X_SIZE, Y_SIZE, NUM_ENGINES, and the dispatcher state enum. The existing queue and combinator use the same package.
- One sub-module, rr_arbiter.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, grant index and grant-valid.
  - Purely combinational; the pointer register lives in pixel_dispatcher.

Test Plan (X_SIZE=4, Y_SIZE=2, NUM_ENGINES=4 unless stated):
1. Reset then frame_start, engines never busy, no queue full.
   - Required: eng_start = 0001,0010,0100,1000,0001,...
   - Required coordinates: (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1).
   - Required: DRAIN then frame_done pulse; 8 issues total.
2. Engine 1 held busy throughout.
   - Required issue sequence: 0001,0100,1000,0001,...; engine 1 never strobed; raster order kept.
3. queue_full=4'b1111 for 5 cycles mid-frame at (2,0), then released.
   - Required: eng_start=0 and coordinates frozen for 5 cycles; next issue is (2,0).
4. Engine 2 stays busy 10 cycles after the final issue.
   - Required: frame_done asserts exactly one cycle after eng_busy returns to 0; frame_busy drops with it.
5. Reset asserted mid-frame at pixel (1,1).
   - Required: next cycle all outputs 0, state IDLE, no frame_done.
   - Required: a new frame_start restarts at (0,0) with pointer 0.
6. frame_start pulsed during DISPATCH and during DRAIN.
   - Required: ignored; exactly one frame_done per accepted start.

Source files
------------

// File: rtl/pixel_dispatcher_pkg.sv
// Shared constants and dispatcher state encoding for the pixel pipeline.
// Used by the dispatcher, the reorder queues and the combinator.
package pixel_dispatcher_pkg;

    localparam int PIXEL_DATA_WIDTH = 10;
    localparam int RBG_SIZE         = 24;
    localparam int X_SIZE           = 640;
    localparam int Y_SIZE           = 480;
    localparam int NUM_ENGINES      = 4;
    localparam int ENG_IDX_WIDTH    = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_DRAIN,
        ST_DONE
    } disp_state_e;

endpackage

// File: rtl/pixel_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr,
// wrapping modulo N. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Scan from ptr upward and keep the first hit.
    always_comb begin
        int k;
        logic [IDX_W-1:0] kk;
        k           = 0;
        kk          = '0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            kk = IDX_W'(k);
            if (!grant_valid && req[kk]) begin
                grant_valid = 1'b1;
                grant_idx   = kk;
                grant[kk]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_dispatcher.sv
// Raster-order frame scheduler issuing one pixel per cycle to a pool of
// engines, round-robin, throttled by engine busy and queue full flags.
module pixel_dispatcher #(
    parameter int NUM_ENGINES      = pixel_dispatcher_pkg::NUM_ENGINES,
    parameter int ENG_IDX_WIDTH    = pixel_dispatcher_pkg::ENG_IDX_WIDTH,
    parameter int PIXEL_DATA_WIDTH = pixel_dispatcher_pkg::PIXEL_DATA_WIDTH,
    parameter int X_SIZE           = pixel_dispatcher_pkg::X_SIZE,
    parameter int Y_SIZE           = pixel_dispatcher_pkg::Y_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic [NUM_ENGINES-1:0]      eng_busy,
    input  logic [NUM_ENGINES-1:0]      queue_full,
    output logic [NUM_ENGINES-1:0]      eng_start,
    output logic [PIXEL_DATA_WIDTH-1:0] xpixel_o,
    output logic [PIXEL_DATA_WIDTH-1:0] ypixel_o,
    output logic                        frame_busy,
    output logic                        frame_done
);

    import pixel_dispatcher_pkg::*;

    localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST =
        PIXEL_DATA_WIDTH'(X_SIZE - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST =
        PIXEL_DATA_WIDTH'(Y_SIZE - 1);
    localparam logic [ENG_IDX_WIDTH-1:0] IDX_LAST =
        ENG_IDX_WIDTH'(NUM_ENGINES - 1);

    disp_state_e state, state_nxt;

    logic [PIXEL_DATA_WIDTH-1:0] x_cnt, y_cnt;
    logic [PIXEL_DATA_WIDTH-1:0] x_nxt, y_nxt;
    logic [PIXEL_DATA_WIDTH-1:0] xpix_nxt, ypix_nxt;
    logic [ENG_IDX_WIDTH-1:0]    rr_ptr, ptr_nxt, gnt_idx;
    logic [NUM_ENGINES-1:0]      eligible, gnt_onehot, start_nxt;
    logic                        gnt_valid, last_pixel;
    logic                        busy_nxt, done_nxt, drain_clear;

    // eng_start doubles as last_issue: it masks the engine whose busy
    // flag has not risen yet.
    assign eligible = (state == ST_DISPATCH)
                    ? (~eng_busy & ~queue_full & ~eng_start)
                    : '0;

    assign last_pixel  = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign drain_clear = (eng_busy == '0) && (eng_start == '0);

    rr_arbiter #(
        .N     (NUM_ENGINES),
        .IDX_W (ENG_IDX_WIDTH)
    ) u_arb (
        .req         (eligible),
        .ptr         (rr_ptr),
        .grant       (gnt_onehot),
        .grant_idx   (gnt_idx),
        .grant_valid (gnt_valid)
    );

    // State and registered outputs; reset aborts any frame silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            x_cnt      <= '0;
            y_cnt      <= '0;
            rr_ptr     <= '0;
            eng_start  <= '0;
            xpixel_o   <= '0;
            ypixel_o   <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            x_cnt      <= x_nxt;
            y_cnt      <= y_nxt;
            rr_ptr     <= ptr_nxt;
            eng_start  <= start_nxt;
            xpixel_o   <= xpix_nxt;
            ypixel_o   <= ypix_nxt;
            frame_busy <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

    // Next-state: final grant moves to DRAIN, idle engines end the frame.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (frame_start) state_nxt = ST_DISPATCH;
            ST_DISPATCH: if (gnt_valid && last_pixel) state_nxt = ST_DRAIN;
            ST_DRAIN:    if (drain_clear) state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and output next values: grant, raster advance, pointer.
    always_comb begin
        x_nxt     = x_cnt;
        y_nxt     = y_cnt;
        ptr_nxt   = rr_ptr;
        start_nxt = '0;
        xpix_nxt  = xpixel_o;
        ypix_nxt  = ypixel_o;
        busy_nxt  = frame_busy;
        done_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    x_nxt    = '0;
                    y_nxt    = '0;
                    busy_nxt = 1'b1;
                end
            end
            ST_DISPATCH: begin
                if (gnt_valid) begin
                    start_nxt = gnt_onehot;
                    xpix_nxt  = x_cnt;
                    ypix_nxt  = y_cnt;
                    ptr_nxt   = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
                    if (x_cnt == X_LAST) begin
                        x_nxt = '0;
                        y_nxt = (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
                    end else begin
                        x_nxt = x_cnt + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_clear) begin
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                end
            end
            ST_DONE: begin
                done_nxt = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule
